// File: rtl/prom_boot_copier.sv
// prom_boot_copier: boot-time copy engine. On start, reads every boot PROM
// word and writes it to RAM at DEST_BASE + 4*index over a req/ack port,
// keeping a running mod-2**32 sum of the words written. done is sticky
// until the next start.
`timescale 1ns/1ps
module prom_boot_copier #(
  parameter int unsigned WORDS     = 1024,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [23:0] DEST_BASE = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              prom_en,
  output logic [ADDR_W-1:0] prom_addr,
  input  logic [31:0]       prom_data,
  output logic              ram_wr,
  output logic [23:0]       ram_adr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ack,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // One extra index bit so WORDS == 2**ADDR_W never wraps back to zero.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(WORDS - 1);

  state_t            state_q,     state_d;
  logic [ADDR_W:0]   idx_q,       idx_d;
  logic [ADDR_W-1:0] prom_addr_q, prom_addr_d;
  logic [23:0]       ram_adr_q,   ram_adr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic [31:0]       sum_q,       sum_d;
  logic              done_q,      done_d;
  logic              prom_en_q,   prom_en_d;
  logic              ram_wr_q,    ram_wr_d;
  logic              busy_q,      busy_d;

  // Byte offset of the current word; truncation gives the mod-2**24 wrap.
  logic [23:0] byte_off;
  assign byte_off = 24'({idx_q, 2'b00});

  // Next-state and datapath decisions for the copy sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ram_adr_d   = ram_adr_q;
    ram_wdata_d = ram_wdata_q;
    sum_d       = sum_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          idx_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // PROM data is valid the cycle after the read enable.
        ram_wdata_d = prom_data;
        ram_adr_d   = DEST_BASE + byte_off;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        // Address/data stay untouched until the write is accepted.
        if (ram_ack) begin
          sum_d = sum_q + ram_wdata_q;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output strobes are registered from the next state so they line up
  // with the state they describe; prom_addr only moves when entering READ.
  always_comb begin
    prom_en_d   = (state_d == S_READ);
    ram_wr_d    = (state_d == S_WRITE);
    busy_d      = (state_d == S_READ) || (state_d == S_LATCH) ||
                  (state_d == S_WRITE);
    prom_addr_d = prom_addr_q;
    if (state_d == S_READ) prom_addr_d = idx_d[ADDR_W-1:0];
  end

  // State and registered outputs; reset abandons any copy in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      prom_addr_q <= '0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      sum_q       <= '0;
      done_q      <= 1'b0;
      prom_en_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      prom_addr_q <= prom_addr_d;
      ram_adr_q   <= ram_adr_d;
      ram_wdata_q <= ram_wdata_d;
      sum_q       <= sum_d;
      done_q      <= done_d;
      prom_en_q   <= prom_en_d;
      ram_wr_q    <= ram_wr_d;
      busy_q      <= busy_d;
    end
  end

  assign prom_en   = prom_en_q;
  assign prom_addr = prom_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_adr   = ram_adr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_prom_boot_copier.sv
// Bench for prom_boot_copier: a 4-word instance driven from a vector table
// plus hand-written reset/start corner cases, and a full 1024-word instance
// with random PROM contents and random ack checked against a reference list.
`timescale 1ns/1ps
module tb_prom_boot_copier;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- small instance: WORDS=4, DEST_BASE=0 ----------------
  logic        start_s, ack_s, prom_en_s, ram_wr_s, busy_s, done_s;
  logic [1:0]  prom_addr_s;
  logic [31:0] prom_data_s, ram_wdata_s, sum_s;
  logic [23:0] ram_adr_s;
  logic [31:0] rom_s [4];

  prom_boot_copier #(.WORDS(4), .ADDR_W(2), .DEST_BASE(24'h000000)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .prom_en(prom_en_s), .prom_addr(prom_addr_s), .prom_data(prom_data_s),
    .ram_wr(ram_wr_s), .ram_adr(ram_adr_s), .ram_wdata(ram_wdata_s), .ram_ack(ack_s),
    .busy(busy_s), .done(done_s), .sum(sum_s));

  always @(posedge clk) if (prom_en_s) prom_data_s <= rom_s[prom_addr_s];

  int stall_word = 0, stall_len = 0, stall_cnt = 0, wr_seen = 0;

  // Ack driver + write checker: every WRITE cycle must present the address
  // and data of the next expected word (also proves stability in a stall).
  always @(negedge clk) begin
    if (ram_wr_s) begin
      if (wr_seen > 3) begin
        checks++; errors++;
        $display("FAIL s_extra_write: got write #%0d expected at most 4", wr_seen + 1);
        ack_s = 1'b1;
      end else begin
        chk("s_wr_adr", 32'(ram_adr_s), 32'(4 * wr_seen));
        chk("s_wr_data", ram_wdata_s, rom_s[wr_seen]);
        if (wr_seen == stall_word && stall_cnt < stall_len) begin
          ack_s = 1'b0;
          stall_cnt++;
        end else begin
          ack_s = 1'b1;
          wr_seen++;
        end
      end
    end else begin
      ack_s = 1'b1;  // ack outside WRITE must be ignored
    end
  end

  // ---------------- full instance: WORDS=1024, DEST_BASE=FFFFF0 ----------
  logic        start_f, ack_f, prom_en_f, ram_wr_f, busy_f, done_f;
  logic [9:0]  prom_addr_f;
  logic [31:0] prom_data_f, ram_wdata_f, sum_f;
  logic [23:0] ram_adr_f;
  logic [31:0] rom_f [1024];
  logic [23:0] q_adr [$];
  logic [31:0] q_dat [$];
  int          waits_f = 0;

  prom_boot_copier #(.WORDS(1024), .ADDR_W(10), .DEST_BASE(24'hFFFFF0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start_f),
    .prom_en(prom_en_f), .prom_addr(prom_addr_f), .prom_data(prom_data_f),
    .ram_wr(ram_wr_f), .ram_adr(ram_adr_f), .ram_wdata(ram_wdata_f), .ram_ack(ack_f),
    .busy(busy_f), .done(done_f), .sum(sum_f));

  always @(posedge clk) if (prom_en_f) prom_data_f <= rom_f[prom_addr_f];

  // Random ack; log every accepted write and count stall cycles.
  always @(negedge clk) begin
    ack_f = ($urandom_range(0, 3) != 0);
    if (ram_wr_f) begin
      if (ack_f) begin
        q_adr.push_back(ram_adr_f);
        q_dat.push_back(ram_wdata_f);
      end else begin
        waits_f++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0][31:0] p;
    int               sw;
    int               sl;
    int               xs;    // cycle after start at which to pulse start again (-1 none)
    logic [31:0]      exp_sum;
    int               exp_cyc;
  } vec_t;

  vec_t vecs [10];

  task automatic pulse_start_s();
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
  endtask

  task automatic run_small(input vec_t v, input string tag);
    int n;
    for (int i = 0; i < 4; i++) rom_s[i] = v.p[i];
    stall_word = v.sw; stall_len = v.sl; stall_cnt = 0; wr_seen = 0;
    pulse_start_s();
    chk({tag, "_busy_after_start"}, 32'(busy_s), 32'd1);
    chk({tag, "_done_cleared"}, 32'(done_s), 32'd0);
    chk({tag, "_sum_cleared"}, sum_s, 32'd0);
    n = 0;
    while (!done_s && n < 200) begin
      @(posedge clk);
      #1 n++;
      start_s = (n == v.xs);
    end
    start_s = 1'b0;
    chk({tag, "_cycles"}, 32'(n), 32'(v.exp_cyc));
    chk({tag, "_sum"}, sum_s, v.exp_sum);
    chk({tag, "_writes"}, 32'(wr_seen), 32'd4);
    chk({tag, "_busy_end"}, 32'(busy_s), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_sticky"}, 32'(done_s), 32'd1);
    chk({tag, "_idle_after"}, 32'(busy_s), 32'd0);
  endtask

  initial begin
    logic [31:0] s;
    int          n;
    logic [31:0] exp_sum_f;
    int          bad;

    // fixed vectors: {p[3],p[2],p[1],p[0]}
    vecs[0] = '{p: {32'd4, 32'd3, 32'd2, 32'd1}, sw: 0, sl: 0, xs: -1, exp_sum: 32'd10, exp_cyc: 12};
    vecs[1] = '{p: {32'd4, 32'd3, 32'd2, 32'd1}, sw: 2, sl: 5, xs: -1, exp_sum: 32'd10, exp_cyc: 17};
    vecs[2] = '{p: {32'd0, 32'd0, 32'd2, 32'hFFFFFFFF}, sw: 0, sl: 0, xs: -1, exp_sum: 32'd1, exp_cyc: 12};
    vecs[3] = '{p: {32'd9, 32'd7, 32'h80000000, 32'h80000000}, sw: 0, sl: 2, xs: 4, exp_sum: 32'd16, exp_cyc: 14};
    vecs[4] = '{p: {32'd0, 32'd0, 32'd0, 32'hDEADBEEF}, sw: 0, sl: 0, xs: 11, exp_sum: 32'hDEADBEEF, exp_cyc: 12};
    vecs[5] = '{p: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, sw: 3, sl: 1, xs: 12,
                exp_sum: 32'hAAAAAAAA, exp_cyc: 13};
    // random vectors, expectations from plain arithmetic
    for (int r = 6; r < 10; r++) begin
      s = 32'd0;
      for (int i = 0; i < 4; i++) begin
        vecs[r].p[i] = $urandom;
        s = s + vecs[r].p[i];
      end
      vecs[r].sw = $urandom_range(0, 3);
      vecs[r].sl = $urandom_range(0, 6);
      vecs[r].xs = -1;
      vecs[r].exp_sum = s;
      vecs[r].exp_cyc = 12 + vecs[r].sl;
    end

    start_s = 1'b0; start_f = 1'b0; ack_s = 1'b1; ack_f = 1'b1;
    for (int i = 0; i < 4; i++) rom_s[i] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_wr", 32'(ram_wr_s), 32'd0);
    chk("rst_prom_en", 32'(prom_en_s), 32'd0);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_sum", sum_s, 32'd0);
    chk("rst_adr", 32'(ram_adr_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) run_small(vecs[v], $sformatf("v%0d", v));

    // Reset during a stalled WRITE of word 2 (sum already 1+2).
    rom_s[0] = 32'd1; rom_s[1] = 32'd2; rom_s[2] = 32'd3; rom_s[3] = 32'd4;
    stall_word = 2; stall_len = 20; stall_cnt = 0; wr_seen = 0;
    pulse_start_s();
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_ram_wr", 32'(ram_wr_s), 32'd1);
    chk("pre_rst_adr", 32'(ram_adr_s), 32'h8);
    chk("pre_rst_sum", sum_s, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_wr", 32'(ram_wr_s), 32'd0);
    chk("mid_rst_busy", 32'(busy_s), 32'd0);
    chk("mid_rst_done", 32'(done_s), 32'd0);
    chk("mid_rst_sum", sum_s, 32'd0);
    chk("mid_rst_wdata", ram_wdata_s, 32'd0);
    chk("mid_rst_prom_addr", 32'(prom_addr_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_resume", 32'(busy_s), 32'd0);
    run_small(vecs[0], "post_rst");

    // Full-size copy with random data and random backpressure.
    exp_sum_f = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      rom_f[i] = $urandom;
      exp_sum_f = exp_sum_f + rom_f[i];
    end
    @(negedge clk);
    q_adr.delete(); q_dat.delete(); waits_f = 0;
    start_f = 1'b1;
    @(posedge clk);
    #1 start_f = 1'b0;
    n = 0;
    while (!done_f && n < 20000) begin
      @(posedge clk);
      #1 n++;
      if (n == 100) start_f = 1'b1;   // start while busy
      else start_f = 1'b0;
    end
    start_f = 1'b0;
    chk("f_done", 32'(done_f), 32'd1);
    chk("f_cycles", 32'(n), 32'(3 * 1024 + waits_f));
    chk("f_count", 32'(q_adr.size()), 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < q_adr.size(); i++) begin
      if (q_adr[i] !== 24'(24'hFFFFF0 + 24'(4 * i)) || q_dat[i] !== rom_f[i]) begin
        if (bad == 0)
          $display("FAIL f_write[%0d]: got (0x%06h,0x%08h) expected (0x%06h,0x%08h)",
                   i, q_adr[i], q_dat[i], 24'(24'hFFFFF0 + 24'(4 * i)), rom_f[i]);
        bad++;
      end
    end
    chk("f_write_mismatches", 32'(bad), 32'd0);
    if (q_adr.size() == 1024) chk("f_last_adr", 32'(q_adr[1023]), 32'h000FEC);
    else chk("f_last_adr_missing", 32'(q_adr.size()), 32'd1024);
    chk("f_sum", sum_f, exp_sum_f);
    chk("f_busy_end", 32'(busy_f), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
